i2s_tx: RTL and testbench

- I2S transmitter for the SGTL5000 codec path; it replaces the direct DOUT->DIN loopback on the Arduino header.
- Accepts stereo PCM sample pairs from the upstream audio logic through a valid/ready handshake and buffers them in a small FIFO.
- Serializes the buffered samples onto I2S_DIN, slaved to the codec-mastered I2S_SCLK and I2S_LRCLK.
- Runs entirely in the 50 MHz system clock domain; SCLK and LRCLK are oversampled through synchronizers, never used as clocks.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_tx_sample_fifo.sv | 57 +++++
 rtl/i2s_tx.sv | 158 +++++++++++++++
 tb/tb_i2s_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit path: the stereo sample pair and the serializer state.
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef struct packed {
    logic signed [SAMPLE_W_DEF-1:0] l;
    logic signed [SAMPLE_W_DEF-1:0] r;
  } stereo_t;

  typedef enum logic {
    IDLE,
    RUN
  } tx_state_t;

endpackage

// File: rtl/i2s_tx_sample_fifo.sv
// Synchronous FIFO of stereo pairs; count registered one cycle after push/pop.
// Head is read combinationally; push when full and pop when empty are ignored (no bypass).
module sample_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  stereo_t                  push_pair,
  input  logic                     pop,
  output stereo_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  stereo_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_pair;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter slaved to codec SCLK/LRCLK, oversampled in the Clk domain; MSB leaves ~3 Clk after
// the first SCLK fall following an LRCLK change. sample_ready drops only while the pair FIFO is full.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          i2s_sclk,
  input  logic                          i2s_lrclk,
  input  logic [SAMPLE_W-1:0]           sample_l,
  input  logic [SAMPLE_W-1:0]           sample_r,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          i2s_din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          underrun
);

  localparam int CW = $clog2(SLOT_W + 1);
  localparam logic [CW-1:0] SAMPLE_C = CW'(SAMPLE_W);
  localparam logic [CW-1:0] SLOT_C   = CW'(SLOT_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic lr_s1, lr_s2;
  logic sclk_rise, sclk_fall;

  logic primed, lr_prev, load_pending, ch;
  tx_state_t state, state_next;
  logic do_load, do_shift, pend_clr, pop;

  logic [SAMPLE_W-1:0] shreg, hold_r, load_word;
  logic [CW-1:0]       bit_cnt;

  stereo_t push_pair, head;
  logic    fifo_full, fifo_empty, push;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;

  assign push_pair.l  = sample_l;
  assign push_pair.r  = sample_r;
  assign sample_ready = ~fifo_full;
  assign push         = sample_valid & sample_ready;
  assign pop          = do_load & ~ch;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .reset     (Reset),
    .push      (push),
    .push_pair (push_pair),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // An empty FIFO at a left boundary sends a silent frame rather than stale data.
  always_comb begin
    load_word = hold_r;
    if (!ch) load_word = fifo_empty ? '0 : head.l;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    pend_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (load_pending) begin
          if (!ch) state_next = RUN;
          else     pend_clr   = 1'b1;
        end
      end
      RUN: begin
        if (sclk_fall) begin
          if (load_pending) begin
            do_load  = 1'b1;
            pend_clr = 1'b1;
          end else begin
            do_shift = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Synchronizers and boundary detect; the first rise after reset only primes lr_prev.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sclk_s1      <= 1'b0;
      sclk_s2      <= 1'b0;
      sclk_s3      <= 1'b0;
      lr_s1        <= 1'b0;
      lr_s2        <= 1'b0;
      primed       <= 1'b0;
      lr_prev      <= 1'b0;
      load_pending <= 1'b0;
      ch           <= 1'b0;
    end else begin
      sclk_s1 <= i2s_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      lr_s1   <= i2s_lrclk;
      lr_s2   <= lr_s1;
      if (sclk_rise) begin
        lr_prev <= lr_s2;
        primed  <= 1'b1;
      end
      if (pend_clr) load_pending <= 1'b0;
      if (sclk_rise && primed && (lr_s2 != lr_prev)) begin
        load_pending <= 1'b1;
        ch           <= lr_s2;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      shreg    <= '0;
      hold_r   <= '0;
      bit_cnt  <= '0;
      i2s_din  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (do_load) begin
        shreg   <= {load_word[SAMPLE_W-2:0], 1'b0};
        i2s_din <= load_word[SAMPLE_W-1];
        bit_cnt <= CNT_ONE;
        if (!ch) hold_r <= fifo_empty ? '0 : head.r;
      end else if (do_shift) begin
        if (bit_cnt < SAMPLE_C) begin
          i2s_din <= shreg[SAMPLE_W-1];
          shreg   <= {shreg[SAMPLE_W-2:0], 1'b0};
        end else begin
          i2s_din <= 1'b0;
        end
        if (bit_cnt != SLOT_C) bit_cnt <= bit_cnt + CNT_ONE;
      end
      if (pop && fifo_empty) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a codec model drives SCLK/LRCLK at 16 Clk per bit, 64 fs, and a
// scoreboard of expected 32-bit slot words is compared against bits captured on each SCLK rise.
module tb_i2s_tx;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        i2s_sclk = 1'b1;
  logic        i2s_lrclk = 1'b1;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        i2s_din;
  logic [2:0]  fifo_count;
  logic        underrun;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] acc = '0;
  int          nb = 0;
  bit          quiet_on = 1'b0;
  logic        quiet_or = 1'b0;

  i2s_tx dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrclk    (i2s_lrclk),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_din      (i2s_din),
    .fifo_count   (fifo_count),
    .underrun     (underrun)
  );

  always #10 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back({l, 16'h0000});
    exp_q.push_back({r, 16'h0000});
  endtask

  task automatic capture();
    acc = {acc[30:0], i2s_din};
    nb++;
    if (nb == 32) begin
      nb = 0;
      chk("scoreboard_has_expect", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("slot_word", acc, exp_q.pop_front());
    end
  endtask

  task automatic fall_half(input logic lr);
    i2s_sclk  = 1'b0;
    i2s_lrclk = lr;
    repeat (8) @(negedge Clk);
  endtask

  task automatic rise_half(input bit cap);
    i2s_sclk = 1'b1;
    if (cap) capture();
    if (quiet_on) quiet_or = quiet_or | i2s_din;
    repeat (8) @(negedge Clk);
  endtask

  // mode 1: check sample_ready rises right after the first left pop; mode 2: push in the pop cycle.
  task automatic run_frames(input int n, input int mode);
    bit pushed;
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < 64; i++) begin
        if (i == 1 && mode != 0) begin
          pushed    = 1'b0;
          i2s_sclk  = 1'b0;
          i2s_lrclk = 1'b0;
          repeat (2) @(negedge Clk);
          if (mode == 1 && f == 0) chk("ready_before_pop", 32'(sample_ready), 32'd0);
          if (mode == 2 && pend_q.size() != 0) begin
            chk("count_before_pushpop", 32'(fifo_count), 32'd2);
            {sample_l, sample_r} = pend_q.pop_front();
            sample_valid = 1'b1;
            pushed = 1'b1;
          end
          @(negedge Clk);
          if (mode == 1 && f == 0) begin
            chk("ready_after_pop", 32'(sample_ready), 32'd1);
            chk("count_after_pop", 32'(fifo_count), 32'd3);
          end
          if (pushed) begin
            sample_valid = 1'b0;
            expect_pair(sample_l, sample_r);
            chk("count_after_pushpop", 32'(fifo_count), 32'd2);
          end
          repeat (5) @(negedge Clk);
        end else begin
          fall_half(i >= 32);
        end
        rise_half(!(f == 0 && i == 0));
      end
    end
    fall_half(1'b1);
    rise_half(1'b1);
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    int w = 0;
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    while (!sample_ready && w < 50) begin
      @(negedge Clk);
      w++;
    end
    chk("push_ready", 32'(sample_ready), 32'd1);
    @(negedge Clk);
    sample_valid = 1'b0;
    expect_pair(l, r);
  endtask

  task automatic reset_pulse();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    int   n_acc;
    int   k;
    logic r;

    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    chk("reset_din", 32'(i2s_din), 32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_ready", 32'(sample_ready), 32'd1);

    // Basic pair.
    push_pair(16'hA5C3, 16'h0F0F);
    chk("count_one", 32'(fifo_count), 32'd1);
    quiet_on = 1'b1;
    quiet_or = 1'b0;
    repeat (2) begin
      fall_half(1'b1);
      rise_half(1'b0);
    end
    quiet_on = 1'b0;
    chk("idle_quiet", 32'(quiet_or), 32'd0);
    run_frames(1, 0);
    chk("basic_underrun", 32'(underrun), 32'd0);
    chk("basic_count", 32'(fifo_count), 32'd0);

    // Underrun on an empty left boundary, sticky across a later push.
    expect_pair(16'h0000, 16'h0000);
    run_frames(1, 0);
    chk("underrun_set", 32'(underrun), 32'd1);
    push_pair(16'h1234, 16'h5678);
    chk("underrun_sticky", 32'(underrun), 32'd1);
    run_frames(1, 0);

    // Fill with valid held high and no codec clocks.
    n_acc = 0;
    k = 0;
    sample_l = 16'hC000;
    sample_r = 16'h3000;
    sample_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      r = sample_ready;
      @(negedge Clk);
      if (r) begin
        expect_pair(sample_l, sample_r);
        n_acc++;
        k++;
        sample_l = 16'hC000 | 16'(k);
        sample_r = 16'h3000 | 16'(k);
      end
    end
    sample_valid = 1'b0;
    chk("fill_accepted", 32'(n_acc), 32'd4);
    chk("fill_ready", 32'(sample_ready), 32'd0);
    chk("fill_count", 32'(fifo_count), 32'd4);
    run_frames(4, 1);
    chk("fill_drained", 32'(fifo_count), 32'd0);

    // Reset, then start codec mid right slot: nothing until the first left boundary.
    reset_pulse();
    chk("reset_clears_underrun", 32'(underrun), 32'd0);
    push_pair(16'hBEEF, 16'h1357);
    quiet_on = 1'b1;
    quiet_or = 1'b0;
    repeat (16) begin
      fall_half(1'b1);
      rise_half(1'b0);
    end
    quiet_on = 1'b0;
    chk("mid_right_quiet", 32'(quiet_or), 32'd0);
    run_frames(1, 0);
    chk("mid_right_underrun", 32'(underrun), 32'd0);

    // Reset in the middle of a left word, while bit 7 of 16'hFFFF is on the wire.
    push_pair(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 9; i++) begin
      fall_half(1'b0);
      rise_half(1'b0);
    end
    i2s_sclk = 1'b0;
    repeat (5) @(negedge Clk);
    chk("bit7_before_reset", 32'(i2s_din), 32'd1);
    reset_pulse();
    chk("midword_reset_din", 32'(i2s_din), 32'd0);
    chk("midword_reset_count", 32'(fifo_count), 32'd0);
    chk("midword_reset_ready", 32'(sample_ready), 32'd1);
    exp_q.delete();
    nb = 0;
    push_pair(16'h6A6A, 16'h9595);
    repeat (2) @(negedge Clk);
    quiet_on = 1'b1;
    quiet_or = 1'b0;
    rise_half(1'b0);
    for (int i = 10; i < 32; i++) begin
      fall_half(1'b0);
      rise_half(1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      fall_half(1'b1);
      rise_half(1'b0);
    end
    quiet_on = 1'b0;
    chk("after_reset_quiet", 32'(quiet_or), 32'd0);
    run_frames(1, 0);

    // Push and pop in the same cycle at count 2; order preserved across pointer wrap.
    push_pair(16'h1111, ~16'h1111);
    push_pair(16'h2222, ~16'h2222);
    chk("wrap_count", 32'(fifo_count), 32'd2);
    for (int p = 3; p <= 6; p++) pend_q.push_back({16'h1111 * 16'(p), ~(16'h1111 * 16'(p))});
    run_frames(4, 2);
    run_frames(2, 0);
    chk("wrap_drained", 32'(fifo_count), 32'd0);
    chk("final_underrun", 32'(underrun), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("bit_alignment", 32'(nb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
